// File: rtl/fir_pkg.sv
// Shared constants for the FIR front half: default sample, product and tap sizes.
package fir_pkg;

  localparam int unsigned FIR_DW   = 16;
  localparam int unsigned FIR_N    = 32;
  localparam int unsigned FIR_TAPS = 4;

  // Products must be exactly double width so that no multiply ever overflows.
  function automatic bit fir_widths_ok(input int unsigned dw, input int unsigned n);
    return n == 2 * dw;
  endfunction

endpackage

// File: rtl/fir_mult.sv
// Combinational signed DW x DW multiply producing the full-precision N-bit product.
module fir_mult
  import fir_pkg::*;
#(
  parameter int unsigned DW = FIR_DW,
  parameter int unsigned N  = FIR_N
) (
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic signed [N-1:0]  prod_c
);

  // Sign-extend both operands first so the N-bit product is exact.
  assign prod_c = N'(a) * N'(b);

endmodule

// File: rtl/fir_tap_mult.sv
// FIR front half: sample delay line, loadable coefficient bank and one registered
// multiply per tap, with a whole-pipeline valid/ready stall.
module fir_tap_mult
  import fir_pkg::*;
#(
  parameter int unsigned DW   = FIR_DW,
  parameter int unsigned N    = FIR_N,
  parameter int unsigned TAPS = FIR_TAPS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [DW-1:0]      x_in,
  input  logic                      coef_we,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic signed [DW-1:0]      coef_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [TAPS*N-1:0]         prod_out
);

  if (!fir_widths_ok(DW, N)) begin : g_bad_width
    $error("fir_tap_mult: N must equal 2*DW");
  end
  if (TAPS < 2) begin : g_bad_taps
    $error("fir_tap_mult: TAPS must be at least 2");
  end

  logic                 adv_c;
  logic                 tap_valid;
  logic signed [DW-1:0] tap  [TAPS];
  logic signed [DW-1:0] coef [TAPS];
  logic [TAPS*N-1:0]    prod_c;

  // Both stages move together; a full, unconsumed output freezes everything.
  assign adv_c    = !out_valid || out_ready;
  assign in_ready = adv_c;

  // Delay line: shifts only when a sample is actually accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < TAPS; k++) tap[k] <= '0;
      tap_valid <= 1'b0;
    end else if (adv_c) begin
      tap_valid <= in_valid;
      if (in_valid) begin
        tap[0] <= x_in;
        for (int unsigned k = 1; k < TAPS; k++) tap[k] <= tap[k-1];
      end
    end
  end

  // Coefficient bank: writable at any time, out-of-range addresses dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < TAPS; k++) coef[k] <= '0;
    end else if (coef_we && (32'(coef_addr) < TAPS)) begin
      coef[coef_addr] <= coef_data;
    end
  end

  for (genvar k = 0; k < TAPS; k++) begin : g_tap
    fir_mult #(
      .DW(DW),
      .N (N)
    ) u_mult (
      .a     (tap[k]),
      .b     (coef[k]),
      .prod_c(prod_c[k*N +: N])
    );
  end

  // Product register; holds together with out_valid while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_out  <= '0;
      out_valid <= 1'b0;
    end else if (adv_c) begin
      prod_out  <= prod_c;
      out_valid <= tap_valid;
    end
  end

endmodule

// File: tb/tb_fir_tap_mult.sv
// Bench for fir_tap_mult: directed stimulus, literal expectations and a
// sample-history model checked on every negative clock edge.
module tb_fir_tap_mult;

  localparam int unsigned DW   = 16;
  localparam int unsigned N    = 32;
  localparam int unsigned TAPS = 4;
  localparam int unsigned T3   = 3;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     in_valid, in_ready, coef_we, out_valid, out_ready;
  logic signed [DW-1:0]     x_in, coef_data;
  logic [1:0]               coef_addr;
  logic [TAPS*N-1:0]        prod_out;

  logic                     v3, ir3, we3, ov3;
  logic signed [DW-1:0]     x3, d3;
  logic [1:0]               a3;
  logic [T3*N-1:0]          p3;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fir_tap_mult #(.DW(DW), .N(N), .TAPS(TAPS)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(out_valid), .out_ready(out_ready), .prod_out(prod_out)
  );

  fir_tap_mult #(.DW(DW), .N(N), .TAPS(T3)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(v3), .in_ready(ir3), .x_in(x3),
    .coef_we(we3), .coef_addr(a3), .coef_data(d3),
    .out_valid(ov3), .out_ready(1'b1), .prod_out(p3)
  );

  task automatic chk(input string name, input logic [TAPS*N-1:0] act, input logic [TAPS*N-1:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, want);
  endtask

  // Model: history of accepted samples (newest first) and current coefficients.
  int                m_h [TAPS];
  int                m_c [TAPS];
  logic              m_pend, m_ov;
  logic [TAPS*N-1:0] m_prod;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) begin m_h[k] = 0; m_c[k] = 0; end
      m_pend = 1'b0; m_ov = 1'b0; m_prod = '0;
    end else begin
      if (!m_ov || out_ready) begin
        if (m_pend)
          for (int k = 0; k < TAPS; k++)
            m_prod[k*N +: N] = N'(longint'(m_h[k]) * longint'(m_c[k]));
        m_ov   = m_pend;
        m_pend = in_valid;
        if (in_valid) begin
          for (int k = TAPS - 1; k > 0; k--) m_h[k] = m_h[k-1];
          m_h[0] = int'(x_in);
        end
      end
      if (coef_we && int'(coef_addr) < TAPS) m_c[coef_addr] = int'(coef_data);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("model_in_ready", {127'd0, in_ready}, {127'd0, (!m_ov || out_ready)});
      chk("model_out_valid", {127'd0, out_valid}, {127'd0, m_ov});
      if (m_ov) chk("model_prod", prod_out, m_prod);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_coef(input logic [1:0] a, input int v);
    coef_we = 1'b1; coef_addr = a; coef_data = DW'(v);
    step();
    coef_we = 1'b0;
  endtask

  task automatic wr3(input logic [1:0] a, input int v);
    we3 = 1'b1; a3 = a; d3 = DW'(v);
    step();
    we3 = 1'b0;
  endtask

  logic [TAPS*N-1:0] want;

  initial begin
    rst = 1'b1; in_valid = 1'b0; x_in = '0; coef_we = 1'b0; coef_addr = '0;
    coef_data = '0; out_ready = 1'b1;
    v3 = 1'b0; x3 = '0; we3 = 1'b0; a3 = '0; d3 = '0;
    #12 rst = 1'b0;
    #1;
    chk("reset_out_valid", {127'd0, out_valid}, '0);
    chk("reset_prod", prod_out, '0);
    chk("reset_in_ready", {127'd0, in_ready}, 128'd1);
    step();

    // Impulse through coefficients 1..4.
    wr_coef(2'd0, 1); wr_coef(2'd1, 2); wr_coef(2'd2, 3); wr_coef(2'd3, 4);
    for (int j = 0; j < 6; j++) begin
      in_valid = (j < 4);
      x_in = (j == 0) ? 16'sd1 : 16'sd0;
      step();
      chk("impulse_valid", {127'd0, out_valid}, {127'd0, (j >= 1 && j <= 4)});
      if (j >= 1 && j <= 4) begin
        want = '0;
        want[(j-1)*N +: N] = N'(j);
        chk("impulse_prod", prod_out, want);
      end
    end
    in_valid = 1'b0;

    // Most-negative operands.
    wr_coef(2'd0, -32768); wr_coef(2'd1, 32767);
    in_valid = 1'b1; x_in = 16'sh8000;
    step();
    step();
    chk("extreme_s0_first", {96'd0, prod_out[31:0]}, 128'h4000_0000);
    in_valid = 1'b0;
    step();
    chk("extreme_s0", {96'd0, prod_out[31:0]}, 128'h4000_0000);
    chk("extreme_s1", {96'd0, prod_out[63:32]}, 128'hC000_8000);

    // Back-pressure for ten cycles.
    wr_coef(2'd0, 1); wr_coef(2'd1, 2);
    in_valid = 1'b1; x_in = 16'sd5;
    step();
    x_in = 16'sd6;
    step();
    chk("bp_first_s0", {96'd0, prod_out[31:0]}, 128'd5);
    out_ready = 1'b0; x_in = 16'sd7;
    #1;
    chk("bp_in_ready", {127'd0, in_ready}, '0);
    for (int j = 0; j < 10; j++) begin
      step();
      chk("bp_hold_valid", {127'd0, out_valid}, 128'd1);
      chk("bp_hold_s0", {96'd0, prod_out[31:0]}, 128'd5);
      chk("bp_hold_in_ready", {127'd0, in_ready}, '0);
    end
    out_ready = 1'b1;
    step();
    chk("bp_rel6_s0", {96'd0, prod_out[31:0]}, 128'd6);
    chk("bp_rel6_s1", {96'd0, prod_out[63:32]}, 128'd10);
    in_valid = 1'b0;
    step();
    chk("bp_rel7_s0", {96'd0, prod_out[31:0]}, 128'd7);
    chk("bp_rel7_s1", {96'd0, prod_out[63:32]}, 128'd12);
    chk("bp_rel7_s2", {96'd0, prod_out[95:64]}, 128'd15);
    step();
    chk("bp_drain", {127'd0, out_valid}, '0);

    // Coefficient rewrite while an output is held.
    in_valid = 1'b1; x_in = 16'sd1;
    step();
    x_in = 16'sd2;
    step();
    chk("coef_old_s2", {96'd0, prod_out[95:64]}, 128'd18);
    in_valid = 1'b0; out_ready = 1'b0;
    coef_we = 1'b1; coef_addr = 2'd2; coef_data = -16'sd1;
    step();
    coef_we = 1'b0;
    chk("coef_held_s2", {96'd0, prod_out[95:64]}, 128'd18);
    out_ready = 1'b1;
    step();
    chk("coef_new_s2", {96'd0, prod_out[95:64]}, 128'hFFFF_FFF9);

    // Gaps in the input stream.
    for (int j = 0; j < 6; j++) begin
      in_valid = (j == 0 || j == 2);
      x_in = (j == 0) ? 16'sd3 : 16'sd4;
      step();
      chk("gap_valid", {127'd0, out_valid}, {127'd0, (j == 1 || j == 3)});
      if (j == 1) chk("gap_s1_a", {96'd0, prod_out[63:32]}, 128'd4);
      if (j == 3) chk("gap_s1_b", {96'd0, prod_out[63:32]}, 128'd6);
    end
    in_valid = 1'b0;

    // Asynchronous reset while an output is valid.
    in_valid = 1'b1; x_in = 16'sd1;
    step();
    in_valid = 1'b0;
    step();
    chk("pre_rst_valid", {127'd0, out_valid}, 128'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", {127'd0, out_valid}, '0);
    chk("async_rst_prod", prod_out, '0);
    #2 rst = 1'b0;
    in_valid = 1'b1; x_in = 16'sd9;
    step();
    in_valid = 1'b0;
    step();
    chk("post_rst_valid", {127'd0, out_valid}, 128'd1);
    chk("post_rst_prod", prod_out, '0);

    // Three-tap instance: address 3 is out of range and must be ignored.
    wr3(2'd0, 2); wr3(2'd1, 3); wr3(2'd2, 5); wr3(2'd3, 100);
    v3 = 1'b1; x3 = 16'sd1;
    step(); step(); step();
    v3 = 1'b0;
    step();
    chk("t3_valid", {127'd0, ov3}, 128'd1);
    chk("t3_prod", {32'd0, p3}, {32'd0, 32'd5, 32'd3, 32'd2});

    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
